// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin through one 4-bit look-ahead slice, LSB nibble first.
// Optional SUB_COMPARE_FLAGS_EN adds unsigned/signed less-than outputs ltu and lts.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
`ifdef SUB_COMPARE_FLAGS_EN
  output logic             ltu,
  output logic             lts,
`endif
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-5:0] res_q, res_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
`ifdef SUB_COMPARE_FLAGS_EN
  logic             ltu_q, ltu_d, lts_q, lts_d;
`endif

  // Look-ahead slice on the low nibble of the shifting operand registers: a + ~b + ~borrow
  logic [3:0]       x, y, p, g, sum;
  logic [4:0]       c;
  logic [WIDTH-1:0] full;

  assign x    = a_q[3:0];
  assign y    = ~b_q[3:0];
  assign p    = x ^ y;
  assign g    = x & y;
  assign c[0] = ~borrow_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sum  = p ^ c[3:0];
  assign full = {sum, res_q};

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    k_d      = k_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`ifdef SUB_COMPARE_FLAGS_EN
    ltu_d    = ltu_q;
    lts_d    = lts_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          k_d      = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        borrow_d = ~c[4];
        k_d      = k_q + KW'(1);
        res_d    = full[WIDTH-1:4];
        // Final nibble: publish the whole result at once, never partial nibbles
        if (k_q == KW'(N - 1)) begin
          state_d = DONE;
          diff_d  = full;
          bout_d  = ~c[4];
          zero_d  = (full == '0);
          ovf_d   = c[3] ^ c[4];
`ifdef SUB_COMPARE_FLAGS_EN
          ltu_d   = ~c[4];
          lts_d   = full[WIDTH-1] ^ c[3] ^ c[4];
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SUB_COMPARE_FLAGS_EN
      ltu_q    <= 1'b0;
      lts_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef SUB_COMPARE_FLAGS_EN
      ltu_q    <= ltu_d;
      lts_q    <= lts_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
`ifdef SUB_COMPARE_FLAGS_EN
  assign ltu  = ltu_q;
  assign lts  = lts_q;
`endif

endmodule
